// File: rtl/csb_pkg.sv
// Shared definitions for the ultrasonic ranging block: FSM encoding,
// result constants, default timing and a counter-width helper.
package csb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_ECHO = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4,
    S_HOLDOFF   = 3'd5
  } csb_state_e;

  localparam logic [15:0] CSB_OUT_OF_RANGE = 16'hFFFF;
  localparam logic [15:0] CSB_CM_MAX       = 16'hFFFE;

  localparam int unsigned CSB_CLK_HZ_DEF     = 50_000_000;
  localparam int unsigned CSB_TRIG_US_DEF    = 10;
  localparam int unsigned CSB_CM_US_DEF      = 58;
  localparam int unsigned CSB_TIMEOUT_US_DEF = 30_000;
  localparam int unsigned CSB_PERIOD_US_DEF  = 60_000;

  // Bits needed to hold values 0..v, never fewer than min_w.
  function automatic int unsigned csb_width(input int unsigned v, input int unsigned min_w);
    int unsigned w;
    w = $clog2(v + 1);
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/csb_us_tick.sv
// Free-running 1 us strobe: one-cycle pulse every CLK_HZ/1_000_000 clocks.
module csb_us_tick
  import csb_pkg::*;
#(
  parameter int unsigned CLK_HZ = CSB_CLK_HZ_DEF
) (
  input  logic Clk,
  input  logic Rst,
  output logic Tick
);

  localparam int unsigned DIV = (CLK_HZ >= 1_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned CW  = csb_width(DIV - 1, 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign Tick = r_tick;

endmodule

// File: rtl/csb_ranging.sv
// Ultrasonic range finder controller: periodic trigger, echo width
// measurement in 1 us ticks, conversion to whole centimetres.
module csb_ranging
  import csb_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CSB_CLK_HZ_DEF,
  parameter int unsigned TRIG_US    = CSB_TRIG_US_DEF,
  parameter int unsigned CM_US      = CSB_CM_US_DEF,
  parameter int unsigned TIMEOUT_US = CSB_TIMEOUT_US_DEF,
  parameter int unsigned PERIOD_US  = CSB_PERIOD_US_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        Echo,
  output logic        Trig,
  output logic [15:0] CSB_data,
  output logic        CSB_valid
);

  localparam int unsigned PW = csb_width(PERIOD_US + TRIG_US + TIMEOUT_US, 16);
  localparam int unsigned TW = csb_width(TIMEOUT_US, 16);
  localparam int unsigned SW = csb_width(CM_US, 1);

  logic w_tick;

  csb_us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .Tick (w_tick)
  );

  // Echo synchroniser followed by a registered edge detector
  logic r_sync1, r_sync2, r_echo_d, r_rise, r_fall;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_echo_d <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1  <= Echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
      r_rise   <= r_sync2 & ~r_echo_d;
      r_fall   <= ~r_sync2 & r_echo_d;
    end
  end

  csb_state_e      r_state, w_state_nxt;
  logic [PW-1:0]   r_period;
  logic [TW-1:0]   r_tmo;
  logic [SW-1:0]   r_sub, w_sub_base;
  logic [15:0]     r_cm, w_cm_base;
  logic            w_meas_start;
  logic            w_load;
  logic [15:0]     w_load_val;
  logic            r_trig, r_valid;
  logic [15:0]     r_data;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_meas_start = 1'b0;
    w_load       = 1'b0;
    w_load_val   = r_data;
    case (r_state)
      S_IDLE: begin
        if (En && w_tick) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (w_tick && r_period == PW'(TRIG_US - 1)) w_state_nxt = S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        if (r_rise) begin
          w_state_nxt  = S_MEASURE;
          w_meas_start = 1'b1;
        end else if (w_tick && r_tmo == TW'(TIMEOUT_US - 1)) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
          w_load_val  = CSB_OUT_OF_RANGE;
        end
      end
      S_MEASURE: begin
        if (r_fall) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
          w_load_val  = r_cm;
        end else if (w_tick && r_tmo == TW'(TIMEOUT_US - 1)) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
          w_load_val  = CSB_OUT_OF_RANGE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        // Leaving one tick early lets IDLE's tick wait land exactly on the period
        if (r_period >= PW'(PERIOD_US - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ticks since the trigger rising edge; drives trigger width and holdoff
  always_ff @(posedge Clk) begin
    if (Rst || r_state == S_IDLE) r_period <= '0;
    else if (w_tick && r_period != '1) r_period <= r_period + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst || r_state == S_TRIG || w_meas_start) r_tmo <= '0;
    else if (w_tick && r_tmo != '1)              r_tmo <= r_tmo + 1'b1;
  end

  // The start edge counts too, so an N-cycle echo always spans exactly N/DIV ticks
  always_comb begin
    w_sub_base = w_meas_start ? '0 : r_sub;
    w_cm_base  = w_meas_start ? '0 : r_cm;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sub <= '0;
      r_cm  <= '0;
    end else if (w_meas_start || r_state == S_MEASURE) begin
      if (w_tick && w_sub_base == SW'(CM_US - 1)) begin
        r_sub <= '0;
        r_cm  <= (w_cm_base == CSB_CM_MAX) ? w_cm_base : w_cm_base + 16'd1;
      end else if (w_tick) begin
        r_sub <= w_sub_base + 1'b1;
        r_cm  <= w_cm_base;
      end else begin
        r_sub <= w_sub_base;
        r_cm  <= w_cm_base;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_trig  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 16'h0000;
    end else begin
      r_trig  <= (w_state_nxt == S_TRIG);
      r_valid <= (w_state_nxt == S_DONE);
      if (w_load) r_data <= w_load_val;
    end
  end

  assign Trig      = r_trig;
  assign CSB_valid = r_valid;
  assign CSB_data  = r_data;

endmodule

// File: tb/tb_csb_ranging.sv
// Scoreboard bench for csb_ranging at a 50 MHz clock, with the us-based
// timing parameters scaled down so every scenario fits a short run.
module tb_csb_ranging;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = 2;
  localparam int TRIG_US    = 10;
  localparam int CM_US      = 58;
  localparam int TIMEOUT_US = 6000;
  localparam int PERIOD_US  = 6500;

  logic        Clk  = 1'b0;
  logic        Rst  = 1'b1;
  logic        En   = 1'b0;
  logic        Echo = 1'b0;
  logic        Trig;
  logic [15:0] CSB_data;
  logic        CSB_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];

  csb_ranging #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .CM_US      (CM_US),
    .TIMEOUT_US (TIMEOUT_US),
    .PERIOD_US  (PERIOD_US)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .En        (En),
    .Echo      (Echo),
    .Trig      (Trig),
    .CSB_data  (CSB_data),
    .CSB_valid (CSB_valid)
  );

  always #10ns Clk = ~Clk;

  always @(posedge Clk) cyc++;

  // Every result pulse is matched against the oldest expected value
  always @(negedge Clk) begin : sb_mon
    logic [15:0] exp_v;
    if (CSB_valid === 1'b1) begin
      vcount++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: CSB_valid with CSB_data=%h, none expected", CSB_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (CSB_data !== exp_v) begin
          n_fail++;
          $display("FAIL sb_data: CSB_data=%h expected %h", CSB_data, exp_v);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Negedges until the chosen output equals lvl; -1 if the budget runs out
  task automatic wait_level(input bit sel_valid, input logic lvl, input int budget,
                            output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge Clk);
      if ((sel_valid ? CSB_valid : Trig) === lvl) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic trig_pulse(input string name);
    int w1, w2;
    wait_level(1'b0, 1'b1, PERIOD_US * DIV + 20, w1);
    wait_level(1'b0, 1'b0, TRIG_US * DIV + 20, w2);
    n_checks++;
    if (w1 < 0 || w2 != TRIG_US * DIV) begin
      n_fail++;
      $display("FAIL %s_trig: rise wait=%0d fall after=%0d required width %0d",
               name, w1, w2, TRIG_US * DIV);
    end
  endtask

  // Echo pulse of width_us starting 50 us after Trig falls
  task automatic measure(input string name, input int width_us, input logic [15:0] exp_v,
                         input bit drop_en);
    int w, v0;
    repeat (50 * DIV) @(negedge Clk);
    Echo = 1'b1;
    exp_q.push_back(exp_v);
    v0 = vcount;
    for (int i = 0; i < width_us * DIV; i++) begin
      @(negedge Clk);
      if (drop_en && i == width_us * DIV / 2) En = 1'b0;
    end
    Echo = 1'b0;
    wait_level(1'b1, 1'b1, 20, w);
    n_checks++;
    if (w != 4) begin
      n_fail++;
      $display("FAIL %s_latency: valid after %0d cycles, required 4", name, w);
    end
    repeat (20) @(negedge Clk);
    n_checks++;
    if (vcount != v0 + 1) begin
      n_fail++;
      $display("FAIL %s_pulses: %0d valid pulses, required 1", name, vcount - v0);
    end
    n_checks++;
    if (CSB_data !== exp_v) begin
      n_fail++;
      $display("FAIL %s_hold: CSB_data=%h required %h", name, CSB_data, exp_v);
    end
  endtask

  task automatic test_reset();
    int w;
    En = 1'b1; Echo = 1'b0; Rst = 1'b1;
    repeat (4) @(negedge Clk);
    n_checks += 3;
    if (Trig !== 1'b0)         begin n_fail++; $display("FAIL rst_trig: %b required 0", Trig); end
    if (CSB_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data: %h required 0000", CSB_data); end
    if (CSB_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: %b required 0", CSB_valid); end
    Rst = 1'b0;
    wait_level(1'b0, 1'b1, 50, w);
    n_checks++;
    if (w < 1 || w > DIV + 2) begin
      n_fail++;
      $display("FAIL first_trig: rose after %0d cycles, required 1..%0d", w, DIV + 2);
    end
    wait_level(1'b0, 1'b0, 100, w);
    n_checks++;
    if (w != TRIG_US * DIV) begin
      n_fail++;
      $display("FAIL trig_width: %0d cycles, required %0d", w, TRIG_US * DIV);
    end
  endtask

  task automatic test_distance(input string name, input int width_us, input logic [15:0] exp_v);
    En = 1'b1; Echo = 1'b0;
    do_reset();
    trig_pulse(name);
    measure(name, width_us, exp_v, 1'b0);
  endtask

  task automatic test_no_echo();
    int w, t0, dt;
    En = 1'b1; Echo = 1'b0;
    do_reset();
    wait_level(1'b0, 1'b1, 20, w);
    t0 = cyc;
    exp_q.push_back(16'hFFFF);
    wait_level(1'b1, 1'b1, (TRIG_US + TIMEOUT_US + 20) * DIV, w);
    dt = cyc - t0;
    n_checks++;
    if (w < 0 || dt < (TRIG_US + TIMEOUT_US - 2) * DIV || dt > (TRIG_US + TIMEOUT_US + 2) * DIV) begin
      n_fail++;
      $display("FAIL noecho_time: valid %0d cycles after Trig, required %0d +/- %0d",
               dt, (TRIG_US + TIMEOUT_US) * DIV, 2 * DIV);
    end
    wait_level(1'b0, 1'b1, PERIOD_US * DIV, w);
    dt = cyc - t0;
    n_checks++;
    if (w < 0 || dt < (PERIOD_US - 2) * DIV || dt > (PERIOD_US + 2) * DIV) begin
      n_fail++;
      $display("FAIL period: next Trig %0d cycles after previous, required %0d +/- %0d",
               dt, PERIOD_US * DIV, 2 * DIV);
    end
    wait_level(1'b0, 1'b0, TRIG_US * DIV + 20, w);
    measure("b2b_trunc", 600, 16'd10, 1'b0);
  endtask

  task automatic test_stuck_high();
    int w, t0, dt;
    En = 1'b1; Echo = 1'b1;
    do_reset();
    wait_level(1'b0, 1'b1, 20, w);
    t0 = cyc;
    exp_q.push_back(16'hFFFF);
    wait_level(1'b1, 1'b1, (TRIG_US + TIMEOUT_US + 20) * DIV, w);
    dt = cyc - t0;
    n_checks++;
    if (w < 0 || dt < (TRIG_US + TIMEOUT_US - 2) * DIV || dt > (TRIG_US + TIMEOUT_US + 2) * DIV) begin
      n_fail++;
      $display("FAIL stuck_time: valid %0d cycles after Trig, required %0d +/- %0d",
               dt, (TRIG_US + TIMEOUT_US) * DIV, 2 * DIV);
    end
    Echo = 1'b0;
  endtask

  task automatic test_en_off();
    int highs, v0;
    En = 1'b0; Echo = 1'b0;
    do_reset();
    highs = 0;
    v0 = vcount;
    repeat (200 * DIV) begin
      @(negedge Clk);
      if (Trig !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0 || vcount != v0) begin
      n_fail++;
      $display("FAIL en_off: Trig high %0d cycles, %0d valids, required 0 and 0", highs, vcount - v0);
    end
  endtask

  task automatic test_en_drop();
    int w;
    En = 1'b1; Echo = 1'b0;
    do_reset();
    trig_pulse("en_drop");
    measure("en_drop", 580, 16'd10, 1'b1);
    wait_level(1'b0, 1'b1, (PERIOD_US + 50) * DIV, w);
    n_checks++;
    if (w != -1) begin
      n_fail++;
      $display("FAIL en_drop_retrig: Trig rose after %0d cycles, required none", w);
    end
  endtask

  // Runs straight after test_en_drop so CSB_data holds a nonzero result
  task automatic test_reset_mid();
    int w, v0;
    En = 1'b1;
    trig_pulse("rst_mid");
    repeat (50 * DIV) @(negedge Clk);
    Echo = 1'b1;
    v0 = vcount;
    repeat (300 * DIV) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    n_checks += 3;
    if (Trig !== 1'b0)         begin n_fail++; $display("FAIL rst_mid_trig: %b required 0", Trig); end
    if (CSB_data !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_data: %h required 0000", CSB_data); end
    if (CSB_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_valid: %b required 0", CSB_valid); end
    Echo = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    wait_level(1'b0, 1'b1, DIV + 2, w);
    n_checks++;
    if (w < 0) begin
      n_fail++;
      $display("FAIL rst_mid_restart: no Trig within %0d cycles of release", DIV + 2);
    end
    wait_level(1'b0, 1'b0, TRIG_US * DIV + 20, w);
    n_checks++;
    if (vcount != v0) begin
      n_fail++;
      $display("FAIL rst_mid_novalid: %0d valid pulses, required 0", vcount - v0);
    end
    measure("rst_mid_after", 1160, 16'd20, 1'b0);
  endtask

  initial begin
    test_reset();
    test_distance("d580", 580, 16'd10);
    test_distance("d5800", 5800, 16'd100);
    test_no_echo();
    test_stuck_high();
    test_en_off();
    test_en_drop();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected results never produced", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csb_ranging.md
CSB_RANGING -- requirements
Module: csb_ranging

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TRIG_US, default 10, trigger pulse width in microseconds.
REQ-003 SHALL have parameter CM_US, default 58, echo microseconds per centimetre.
REQ-004 SHALL have parameter TIMEOUT_US, default 30000, maximum wait for echo start and maximum echo width.
REQ-005 SHALL have parameter PERIOD_US, default 60000, minimum spacing between trigger rising edges.
REQ-006 SHALL have port Clk, input, 1 bit, the single clock; one clock, all logic on rising edge.
REQ-007 SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port En, input, 1 bit, enable for continuous ranging.
REQ-009 SHALL have port Echo, input, 1 bit, asynchronous echo line from the ultrasonic sensor.
REQ-010 SHALL have port Trig, output, 1 bit, sensor trigger pulse.
REQ-011 SHALL have port CSB_data, output, 16 bits, last distance in cm; 16'hFFFF means out of range.
REQ-012 SHALL have port CSB_valid, output, 1 bit, one-cycle pulse when CSB_data updates.

Function
REQ-013 SHALL derive a 1 us tick: one-cycle pulse every CLK_HZ/1_000_000 clocks, free-running after reset.
REQ-014 SHALL pass Echo through a 2-flop synchroniser, then a registered edge detector, before any use.
REQ-015 SHALL implement FSM states IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF.
REQ-016 IDLE: while En=1 and the next tick arrives, go to TRIG; while En=0, stay in IDLE with Trig=0.
REQ-017 TRIG: Trig=1 for exactly TRIG_US ticks, then go to WAIT_ECHO.
REQ-018 WAIT_ECHO: on a synchronised Echo rising edge, go to MEASURE with cleared counters; after TIMEOUT_US ticks with no rise, load CSB_data=16'hFFFF and go to DONE.
REQ-019 MEASURE: count ticks in a sub-counter modulo CM_US; each wrap increments a centimetre counter.
REQ-020 The centimetre counter SHALL saturate at 16'hFFFE.
REQ-021 MEASURE: on a synchronised falling edge, load CSB_data with the cm counter, truncated (a partial CM_US is discarded), and go to DONE.
REQ-022 MEASURE: if the echo stays high for TIMEOUT_US ticks, load 16'hFFFF and go to DONE.
REQ-023 DONE: lasts one cycle; CSB_valid=1 in that cycle only; go to HOLDOFF.
REQ-024 CSB_valid SHALL occur 1 cycle after the cycle in which the falling edge is detected.
REQ-025 HOLDOFF: wait until PERIOD_US ticks have elapsed since the Trig rising edge, then go to IDLE.
REQ-026 HOLDOFF: any Echo activity SHALL be ignored.
REQ-027 En deasserted mid-measurement SHALL NOT abort; the current cycle completes through HOLDOFF, then the FSM rests in IDLE.
REQ-028 An Echo already high on entry to WAIT_ECHO SHALL NOT count as a rising edge.
REQ-029 CSB_data SHALL hold its value between updates.

Reset
REQ-030 On Rst=1 at a clock edge:
- state=IDLE, Trig=0, CSB_data=16'h0000, CSB_valid=0;
- all counters, tick prescaler and synchroniser flops cleared.
REQ-031 Reset mid-measurement SHALL abandon the cycle with no CSB_valid pulse.
REQ-032 First Trig after reset release SHALL rise within CLK_HZ/1_000_000+2 cycles if En=1.

Structure
REQ-033 SHALL place FSM state encoding, the 16'hFFFF out-of-range constant and default timing values in shared package csb_pkg.
REQ-034 SHALL implement the 1 us prescaler as sub-module csb_us_tick (Clk, Rst, tick output).
REQ-035 Counter widths SHALL be sized from the parameters, at least 16 bits for the tick timers.

Verification
REQ-036 Bench SHALL run at 50 MHz (20 ns period). Scenarios, stimulus -> required response:
- Echo high 580 us after Trig -> CSB_data=10, one CSB_valid pulse.
- Echo high 5800 us -> CSB_data=100; Echo high 600 us -> CSB_data=10 (truncation).
- No echo -> CSB_data=16'hFFFF, CSB_valid 30010 us after Trig rise (±2 ticks); next Trig at 60000 us.
- Echo stuck high from before WAIT_ECHO -> no measurement start; timeout gives 16'hFFFF.
- En=0 -> Trig stays 0; En dropped in MEASURE -> result still reported, then no further Trig.
- Rst pulsed mid-MEASURE -> Trig=0, CSB_data=0, no CSB_valid; restart after release.
